// File: rtl/hazard_forwarding_unit.sv
// -----------------------------------------------------------------------------
// HazardForwarding: pipeline hazard controller for the ID stage.
//
// Keeps a shadow copy of the destination-register info of the instructions
// currently in EX, MEM and WB. From that it derives:
//   - operand-forwarding selects for the three register-file read ports,
//   - the PC load enable handed to the register file (R15),
//   - the IF/ID load enable (held low on a load-use stall),
//   - the ID/EX bubble select (stall or taken-branch flush),
//   - saturating counters of stall cycles and flush cycles.
//
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   ID_SA/ID_SB/ID_SD [3:0]    source register indices of the ID instruction
//   ID_useA/useB/useD          the matching source is really read
//   ID_C [3:0], ID_RFLd        destination index / register-write flag of ID
//   ID_load                    the ID instruction is a memory load
//   EX_flush                   taken branch resolved in EX, squash ID
//   HZPCld                     PC load enable (0 = hold PC)
//   IFIDLd                     IF/ID load enable
//   NOPsel                     1 = ID/EX receives a bubble
//   FWD_A/FWD_B/FWD_D [1:0]    00 RF, 01 EX, 10 MEM, 11 WB value
//   STALLcnt, FLUSHcnt [15:0]  saturating event counters
// -----------------------------------------------------------------------------
module hazard_forwarding_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  ID_SA,
  input  logic [3:0]  ID_SB,
  input  logic [3:0]  ID_SD,
  input  logic        ID_useA,
  input  logic        ID_useB,
  input  logic        ID_useD,
  input  logic [3:0]  ID_C,
  input  logic        ID_RFLd,
  input  logic        ID_load,
  input  logic        EX_flush,
  output logic        HZPCld,
  output logic        IFIDLd,
  output logic        NOPsel,
  output logic [1:0]  FWD_A,
  output logic [1:0]  FWD_B,
  output logic [1:0]  FWD_D,
  output logic [15:0] STALLcnt,
  output logic [15:0] FLUSHcnt
);

  typedef struct packed {
    logic [3:0] c;
    logic       rfLd;
    logic       load;
  } slot_t;

  localparam logic [3:0]  PcReg  = 4'hF;
  localparam logic [15:0] CntMax = 16'hFFFF;

  slot_t       exQ, memQ, wbQ;
  slot_t       exD;
  logic [15:0] stallCntQ, stallCntD;
  logic [15:0] flushCntQ, flushCntD;
  logic        loadUse;

  // A source matches a slot when that slot writes exactly this register.
  // R15 is the PC and always comes straight from the register file.
  function automatic logic slotMatch(input slot_t s, input logic [3:0] src);
    return s.rfLd && (s.c == src) && (src != PcReg);
  endfunction

  // Youngest writer wins: EX before MEM before WB.
  function automatic logic [1:0] fwdSelect(input slot_t ex, input slot_t mem,
                                           input slot_t wb, input logic [3:0] src);
    if (slotMatch(ex, src))       return 2'b01;
    else if (slotMatch(mem, src)) return 2'b10;
    else if (slotMatch(wb, src))  return 2'b11;
    else                          return 2'b00;
  endfunction

  // Forward selects are produced for every port, whether the port is used or
  // not; only the stall decision looks at the use flags.
  always_comb begin
    FWD_A = fwdSelect(exQ, memQ, wbQ, ID_SA);
    FWD_B = fwdSelect(exQ, memQ, wbQ, ID_SB);
    FWD_D = fwdSelect(exQ, memQ, wbQ, ID_SD);
  end

  // Load-use: a load in EX produces its data too late for the ID consumer,
  // so ID must wait one cycle and pick the value up from MEM instead.
  always_comb begin
    loadUse = exQ.load && exQ.rfLd &&
              ((ID_useA && slotMatch(exQ, ID_SA)) ||
               (ID_useB && slotMatch(exQ, ID_SB)) ||
               (ID_useD && slotMatch(exQ, ID_SD)));
  end

  // A flush overrides the stall: the instruction that caused the hazard is
  // being squashed anyway, so fetch proceeds and only a bubble goes forward.
  always_comb begin
    HZPCld = 1'b1;
    IFIDLd = 1'b1;
    NOPsel = 1'b0;
    if (EX_flush) begin
      NOPsel = 1'b1;
    end else if (loadUse) begin
      HZPCld = 1'b0;
      IFIDLd = 1'b0;
      NOPsel = 1'b1;
    end
  end

  // Next EX slot and saturating counter updates.
  always_comb begin
    exD       = NOPsel ? '0 : slot_t'{c: ID_C, rfLd: ID_RFLd, load: ID_load};
    stallCntD = stallCntQ;
    flushCntD = flushCntQ;
    if (EX_flush) begin
      if (flushCntQ != CntMax) flushCntD = flushCntQ + 16'd1;
    end else if (loadUse) begin
      if (stallCntQ != CntMax) stallCntD = stallCntQ + 16'd1;
    end
  end

  // Shadow pipeline advances every edge; reset clears slots and counters,
  // which also drops any stall in progress without counting it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      exQ       <= '0;
      memQ      <= '0;
      wbQ       <= '0;
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      wbQ       <= memQ;
      memQ      <= exQ;
      exQ       <= exD;
      stallCntQ <= stallCntD;
      flushCntQ <= flushCntD;
    end
  end

  assign STALLcnt = stallCntQ;
  assign FLUSHcnt = flushCntQ;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// -----------------------------------------------------------------------------
// Testbench for hazard_forwarding_unit.
// A behavioural model tracks the three in-flight instructions as a small
// array (index 0 = youngest) and unbounded integer event counts; a compare
// process checks every DUT output against it on each falling edge. Directed
// sequences add literal expectations, then random traffic and a long flush
// run follow.
// -----------------------------------------------------------------------------
module tb_hazard_forwarding_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  ID_SA, ID_SB, ID_SD, ID_C;
  logic        ID_useA, ID_useB, ID_useD, ID_RFLd, ID_load, EX_flush;
  logic        HZPCld, IFIDLd, NOPsel;
  logic [1:0]  FWD_A, FWD_B, FWD_D;
  logic [15:0] STALLcnt, FLUSHcnt;

  int testsRun = 0;
  int testsFailed = 0;

  hazard_forwarding_unit dut (
    .CLK(CLK), .RST(RST),
    .ID_SA(ID_SA), .ID_SB(ID_SB), .ID_SD(ID_SD),
    .ID_useA(ID_useA), .ID_useB(ID_useB), .ID_useD(ID_useD),
    .ID_C(ID_C), .ID_RFLd(ID_RFLd), .ID_load(ID_load),
    .EX_flush(EX_flush),
    .HZPCld(HZPCld), .IFIDLd(IFIDLd), .NOPsel(NOPsel),
    .FWD_A(FWD_A), .FWD_B(FWD_B), .FWD_D(FWD_D),
    .STALLcnt(STALLcnt), .FLUSHcnt(FLUSHcnt)
  );

  always #5 CLK = ~CLK;

  // Model state: in-flight writers, youngest first, and raw event counts.
  typedef struct {
    int dest;
    bit writes;
    bit isLoad;
  } instr_t;

  instr_t inFlight[3];
  int     stallEvents = 0;
  int     flushEvents = 0;
  bit     mLu, mNop;

  // Which pipeline position (1 = EX, 2 = MEM, 3 = WB) supplies register r,
  // or 0 when the register file does.
  function automatic int modelFwd(input int r);
    if (r == 15) return 0;
    for (int k = 0; k < 3; k++)
      if (inFlight[k].writes && inFlight[k].dest == r) return k + 1;
    return 0;
  endfunction

  function automatic bit modelLoadUse();
    if (!(inFlight[0].isLoad && inFlight[0].writes)) return 0;
    return (ID_useA && modelFwd(int'(ID_SA)) == 1) ||
           (ID_useB && modelFwd(int'(ID_SB)) == 1) ||
           (ID_useD && modelFwd(int'(ID_SD)) == 1);
  endfunction

  function automatic int sat16(input int n);
    return (n > 65535) ? 65535 : n;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 3; k++) inFlight[k] = '{0, 0, 0};
      stallEvents = 0;
      flushEvents = 0;
    end else begin
      mLu  = modelLoadUse();
      mNop = EX_flush || mLu;
      if (EX_flush)  flushEvents++;
      else if (mLu)  stallEvents++;
      inFlight[2] = inFlight[1];
      inFlight[1] = inFlight[0];
      if (mNop) inFlight[0] = '{0, 0, 0};
      else      inFlight[0] = '{int'(ID_C), ID_RFLd, ID_load};
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model, away from the rising edge.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      bit lu;
      lu = modelLoadUse();
      checkOutput("FWD_A", int'(FWD_A), modelFwd(int'(ID_SA)));
      checkOutput("FWD_B", int'(FWD_B), modelFwd(int'(ID_SB)));
      checkOutput("FWD_D", int'(FWD_D), modelFwd(int'(ID_SD)));
      checkOutput("HZPCld", int'(HZPCld), (EX_flush || !lu) ? 1 : 0);
      checkOutput("IFIDLd", int'(IFIDLd), (EX_flush || !lu) ? 1 : 0);
      checkOutput("NOPsel", int'(NOPsel), (EX_flush || lu) ? 1 : 0);
      checkOutput("STALLcnt", int'(STALLcnt), sat16(stallEvents));
      checkOutput("FLUSHcnt", int'(FLUSHcnt), sat16(flushEvents));
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Present an ID instruction: destination info plus sources and use flags.
  task automatic applyStimulus(input int c, input bit rfLd, input bit ld,
                               input int sa, input int sb, input int sd,
                               input bit ua, input bit ub, input bit ud,
                               input bit flush);
    ID_C     = 4'(c);
    ID_RFLd  = rfLd;
    ID_load  = ld;
    ID_SA    = 4'(sa);
    ID_SB    = 4'(sb);
    ID_SD    = 4'(sd);
    ID_useA  = ua;
    ID_useB  = ub;
    ID_useD  = ud;
    EX_flush = flush;
    #1;
  endtask

  function automatic int randReg();
    int v;
    v = int'($urandom_range(0, 4));
    return (v == 4) ? 15 : v;
  endfunction

  initial begin
    // Reset held two edges while ID carries a load to R3 reading R3.
    RST = 1'b1;
    applyStimulus(3, 1, 1, 3, 3, 3, 1, 1, 1, 0);
    tick();
    tick();
    RST = 1'b0;
    #1;
    checkOutput("reset FWD_A", int'(FWD_A), 0);
    checkOutput("reset HZPCld", int'(HZPCld), 1);
    checkOutput("reset NOPsel", int'(NOPsel), 0);
    checkOutput("reset STALLcnt", int'(STALLcnt), 0);
    checkOutput("reset FLUSHcnt", int'(FLUSHcnt), 0);

    // Forward chain: writers of R1, R2, R3 then readers of 1/2/3.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(2, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(3, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 1, 2, 3, 1, 1, 1, 0);
    checkOutput("chain FWD_A", int'(FWD_A), 3);
    checkOutput("chain FWD_B", int'(FWD_B), 2);
    checkOutput("chain FWD_D", int'(FWD_D), 1);

    // Three writers of R3: the youngest (EX) wins on every port.
    applyStimulus(3, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(3, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(3, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 3, 3, 3, 1, 1, 1, 0);
    checkOutput("allR3 FWD_A", int'(FWD_A), 1);
    checkOutput("allR3 FWD_B", int'(FWD_B), 1);
    checkOutput("allR3 FWD_D", int'(FWD_D), 1);

    // Load-use on R5: one stall cycle, then MEM forwarding.
    applyStimulus(5, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 5, 0, 0, 1, 0, 0, 0);
    checkOutput("lu HZPCld", int'(HZPCld), 0);
    checkOutput("lu IFIDLd", int'(IFIDLd), 0);
    checkOutput("lu NOPsel", int'(NOPsel), 1);
    tick();
    #1;
    checkOutput("lu STALLcnt", int'(STALLcnt), 1);
    checkOutput("lu after FWD_A", int'(FWD_A), 2);
    checkOutput("lu after NOPsel", int'(NOPsel), 0);

    // Unused source matching a load in EX: no stall, select still 01.
    applyStimulus(5, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    checkOutput("unused NOPsel", int'(NOPsel), 0);
    checkOutput("unused FWD_B", int'(FWD_B), 1);

    // Flush together with a load-use: flush wins, no stall counted.
    applyStimulus(5, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 5, 0, 0, 1, 0, 0, 1);
    checkOutput("flush HZPCld", int'(HZPCld), 1);
    checkOutput("flush NOPsel", int'(NOPsel), 1);
    tick();
    applyStimulus(0, 0, 0, 5, 0, 0, 1, 0, 0, 0);
    checkOutput("flush STALLcnt", int'(STALLcnt), 1);
    checkOutput("flush FLUSHcnt", int'(FLUSHcnt), 1);
    checkOutput("flush bubble FWD_A", int'(FWD_A), 2);
    checkOutput("flush bubble NOPsel", int'(NOPsel), 0);

    // R15 is never forwarded.
    applyStimulus(15, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 15, 15, 15, 1, 1, 1, 0);
    checkOutput("R15 FWD_A", int'(FWD_A), 0);

    // Random traffic with occasional resets and flushes.
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 63) == 0);
      applyStimulus(randReg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    randReg(), randReg(), randReg(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      tick();
    end

    // Reset mid-stall: the stall is dropped and not counted.
    RST = 1'b0;
    applyStimulus(5, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 5, 0, 0, 1, 0, 0, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    checkOutput("rst midstall STALLcnt", int'(STALLcnt), 0);
    checkOutput("rst midstall NOPsel", int'(NOPsel), 0);

    // Back-to-back flushes until the flush counter saturates.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 65540; i++) tick();
    #1;
    checkOutput("FLUSHcnt saturated", int'(FLUSHcnt), 65535);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
